// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, reset vector and datapath width.
package pipeline_pkg;

    localparam int unsigned FETCH_ADDR_W   = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns the PC, fetches over a req/ack instruction-memory handshake
// and holds one instruction (plus its PC+4) until IF/ID takes it.
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned        ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              REDIRECT_IN,
    input  logic [ADDR_W-1:0] REDIRECT_ADDR_IN,
    output logic              IM_REQ,
    output logic [ADDR_W-1:0] IM_ADDR,
    input  logic              IM_ACK,
    input  logic [ADDR_W-1:0] IM_DATA,
    output logic [ADDR_W-1:0] Instruction_OUT,
    output logic [ADDR_W-1:0] InstructionAddressPlus4_OUT,
    output logic              FETCH_VALID_OUT
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [ADDR_W-1:0] ibuf_q;
    logic [ADDR_W-1:0] ibuf_pc4_q;
    logic              ibuf_valid_q;

    logic              space;
    logic              consume;
    logic              capture;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redirect_target;

    assign space           = !ibuf_valid_q || !STALL;
    assign consume         = ibuf_valid_q && !STALL;
    assign pc_plus4        = pc_q + ADDR_W'(4);
    assign redirect_target = REDIRECT_ADDR_IN & ~ADDR_W'(3);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_IDLE: begin
                if (IM_REQ && !IM_ACK) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (IM_ACK)           state_d = FETCH_IDLE;
                else if (REDIRECT_IN) state_d = FETCH_DROP;
            end
            FETCH_DROP: begin
                if (IM_ACK) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // The open request's address is latched so a redirect can move the PC
    // while the memory still sees the original, stable IM_ADDR.
    always_comb begin
        IM_REQ  = 1'b0;
        IM_ADDR = pc_q;
        capture = 1'b0;
        if (!RESET) begin
            unique case (state_q)
                FETCH_IDLE: begin
                    IM_REQ  = space && !REDIRECT_IN;
                    capture = IM_REQ && IM_ACK;
                end
                FETCH_WAIT: begin
                    IM_REQ  = 1'b1;
                    IM_ADDR = req_addr_q;
                    capture = IM_ACK && !REDIRECT_IN;
                end
                FETCH_DROP: begin
                    IM_REQ  = 1'b1;
                    IM_ADDR = req_addr_q;
                end
                default: begin
                    IM_REQ  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            req_addr_q <= RESET_PC;
        end else if (state_q == FETCH_IDLE && IM_REQ && !IM_ACK) begin
            req_addr_q <= pc_q;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc_q         <= RESET_PC;
            ibuf_q       <= '0;
            ibuf_pc4_q   <= '0;
            ibuf_valid_q <= 1'b0;
        end else if (REDIRECT_IN) begin
            pc_q         <= redirect_target;
            ibuf_valid_q <= 1'b0;
        end else if (capture) begin
            pc_q         <= pc_plus4;
            ibuf_q       <= IM_DATA;
            ibuf_pc4_q   <= pc_plus4;
            ibuf_valid_q <= 1'b1;
        end else if (consume) begin
            ibuf_valid_q <= 1'b0;
        end
    end

    assign Instruction_OUT             = ibuf_valid_q ? ibuf_q     : ADDR_W'(NOP_INSTR);
    assign InstructionAddressPlus4_OUT = ibuf_valid_q ? ibuf_pc4_q : '0;
    assign FETCH_VALID_OUT             = ibuf_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: transaction-level fetch model plus a
// variable-latency memory, directed scenarios followed by randomized traffic.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        REDIRECT_IN = 1'b0;
    logic [31:0] REDIRECT_ADDR_IN = '0;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic        IM_ACK = 1'b0;
    logic [31:0] IM_DATA = '0;
    logic [31:0] Instruction_OUT;
    logic [31:0] InstructionAddressPlus4_OUT;
    logic        FETCH_VALID_OUT;

    always #5 CLOCK = ~CLOCK;

    if_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .CLOCK                       (CLOCK),
        .RESET                       (RESET),
        .STALL                       (STALL),
        .REDIRECT_IN                 (REDIRECT_IN),
        .REDIRECT_ADDR_IN            (REDIRECT_ADDR_IN),
        .IM_REQ                      (IM_REQ),
        .IM_ADDR                     (IM_ADDR),
        .IM_ACK                      (IM_ACK),
        .IM_DATA                     (IM_DATA),
        .Instruction_OUT             (Instruction_OUT),
        .InstructionAddressPlus4_OUT (InstructionAddressPlus4_OUT),
        .FETCH_VALID_OUT             (FETCH_VALID_OUT)
    );

    int total = 0;
    int bad   = 0;

    // Model: program counter, one outstanding memory transaction, one-entry buffer.
    logic [31:0] m_pc    = RST_PC;
    bit          m_pend  = 1'b0;
    logic [31:0] m_paddr = '0;
    bit          m_pdisc = 1'b0;
    bit          m_bv    = 1'b0;
    logic [31:0] m_bdata = '0;
    logic [31:0] m_bpc4  = '0;
    logic [31:0] m_seq   = RST_PC;
    bit          checking = 1'b0;

    int mem_cnt = 0;
    int mem_lat = 0;
    int lat_lo  = 0;
    int lat_hi  = 0;

    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_lat(input int lo, input int hi);
        lat_lo  = lo;
        lat_hi  = hi;
        mem_lat = lo;
    endtask

    task automatic cycle(input bit rst, input bit stl, input bit rdr, input logic [31:0] tgt);
        bit          space, e_req, got, useful, consume;
        logic [31:0] e_addr;
        @(negedge CLOCK);
        RESET            = rst;
        STALL            = stl;
        REDIRECT_IN      = rdr;
        REDIRECT_ADDR_IN = tgt;
        IM_ACK           = 1'b0;
        IM_DATA          = $urandom;
        #1;
        space  = !m_bv || !stl;
        e_req  = !rst && (m_pend || (space && !rdr));
        e_addr = (m_pend && !rst) ? m_paddr : m_pc;
        if (checking) begin
            chk("im_req",    {31'b0, IM_REQ},          {31'b0, e_req});
            chk("im_addr",   IM_ADDR,                  e_addr);
            chk("valid",     {31'b0, FETCH_VALID_OUT}, {31'b0, m_bv});
            chk("instr",     Instruction_OUT,             m_bv ? m_bdata : 32'h0);
            chk("pc_plus4",  InstructionAddressPlus4_OUT, m_bv ? m_bpc4  : 32'h0);
        end
        last_req  = IM_REQ;
        last_addr = IM_ADDR;
        if (IM_REQ && mem_cnt >= mem_lat) begin
            IM_ACK  = 1'b1;
            IM_DATA = memf(IM_ADDR);
        end
        #1;
        got = e_req && IM_ACK;
        if (rst) begin
            mem_cnt = 0;
        end else if (IM_ACK) begin
            mem_cnt = 0;
            mem_lat = $urandom_range(lat_hi, lat_lo);
        end else if (IM_REQ) begin
            mem_cnt++;
        end
        // Everything IF/ID takes must be the sequential path from the last reset/redirect.
        consume = m_bv && !stl && !rst;
        if (consume && checking) begin
            chk("stream_pc",   InstructionAddressPlus4_OUT - 32'd4, m_seq);
            chk("stream_data", Instruction_OUT, memf(m_seq));
            m_seq = m_seq + 32'd4;
        end
        if (rst) begin
            m_pc = RST_PC; m_pend = 1'b0; m_pdisc = 1'b0;
            m_bv = 1'b0; m_bdata = '0; m_bpc4 = '0; m_seq = RST_PC;
        end else begin
            useful = got && !(m_pend && m_pdisc) && !rdr;
            if (rdr)          m_bv = 1'b0;
            else if (useful)  m_bv = 1'b1;
            else if (consume) m_bv = 1'b0;
            if (useful) begin
                m_bdata = memf(e_addr);
                m_bpc4  = e_addr + 32'd4;
            end
            if (e_req && !IM_ACK) begin
                if (!m_pend) begin
                    m_paddr = m_pc;
                    m_pdisc = 1'b0;
                end
                m_pend = 1'b1;
                if (rdr) m_pdisc = 1'b1;
            end else begin
                m_pend = 1'b0;
            end
            if (rdr) begin
                m_pc  = tgt & ~32'd3;
                m_seq = tgt & ~32'd3;
            end else if (useful) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        set_lat(0, 0);
        cycle(1, 0, 0, 0);
        checking = 1'b1;
        cycle(1, 0, 0, 0);
        chk("rst_req",   {31'b0, last_req}, 32'd0);
        chk("rst_valid", {31'b0, FETCH_VALID_OUT}, 32'd0);
        chk("rst_instr", Instruction_OUT, 32'h0);

        // Zero-wait streaming
        cycle(0, 0, 0, 0);
        chk("zw_addr0", last_addr, 32'h0040_0000);
        chk("zw_instr0", Instruction_OUT, 32'h1317_9BDF);
        chk("zw_pc4_0", InstructionAddressPlus4_OUT, 32'h0040_0004);
        cycle(0, 0, 0, 0);
        chk("zw_addr1", last_addr, 32'h0040_0004);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("zw_valid", {31'b0, FETCH_VALID_OUT}, 32'd1);

        // Stall with a full buffer
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            chk("stall_req", {31'b0, last_req}, 32'd0);
        end
        chk("stall_pc4", InstructionAddressPlus4_OUT, 32'h0040_0010);
        cycle(0, 0, 0, 0);
        chk("resume_addr", last_addr, 32'h0040_0010);

        // Redirect during a 3-cycle wait
        set_lat(3, 3);
        cycle(0, 0, 1, 32'h0040_0010);
        cycle(0, 0, 0, 0);
        chk("lat_valid", {31'b0, FETCH_VALID_OUT}, 32'd0);
        chk("lat_instr", Instruction_OUT, 32'h0);
        cycle(0, 0, 1, 32'h0040_0103);
        chk("drop_addr_b", last_addr, 32'h0040_0010);
        cycle(0, 0, 0, 0);
        chk("drop_addr_c", last_addr, 32'h0040_0010);
        cycle(0, 0, 0, 0);
        chk("drop_discard", {31'b0, FETCH_VALID_OUT}, 32'd0);
        cycle(0, 0, 0, 0);
        chk("tgt_addr", last_addr, 32'h0040_0100);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        chk("tgt_pc4", InstructionAddressPlus4_OUT, 32'h0040_0104);

        // Redirect together with stall on a full buffer
        set_lat(0, 0);
        cycle(0, 1, 1, 32'h0040_0200);
        chk("rs_valid", {31'b0, FETCH_VALID_OUT}, 32'd0);
        cycle(0, 0, 0, 0);
        chk("rs_addr", last_addr, 32'h0040_0200);

        // Reset in the middle of a wait
        set_lat(3, 3);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rw_req", {31'b0, last_req}, 32'd0);
        chk("rw_valid", {31'b0, FETCH_VALID_OUT}, 32'd0);
        set_lat(0, 0);
        cycle(0, 0, 0, 0);
        chk("rw_addr", last_addr, 32'h0040_0000);

        // PC wrap at the top of the address space
        cycle(0, 0, 1, 32'hFFFF_FFFF);
        cycle(0, 0, 0, 0);
        chk("wrap_addr", last_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", InstructionAddressPlus4_OUT, 32'h0);
        cycle(0, 0, 0, 0);
        chk("wrap_next", last_addr, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit          r_rst, r_stl, r_rdr;
            logic [31:0] r_tgt;
            if (n % 250 == 0) begin
                case ($urandom_range(3, 0))
                    0:       set_lat(0, 0);
                    1:       set_lat(0, 2);
                    2:       set_lat(1, 4);
                    default: set_lat(3, 3);
                endcase
            end
            r_rst = ($urandom_range(199, 0) == 0);
            r_stl = ($urandom_range(99, 0) < 30);
            r_rdr = ($urandom_range(99, 0) < 6);
            case ($urandom_range(2, 0))
                0:       r_tgt = $urandom;
                1:       r_tgt = 32'hFFFF_FFF0 + $urandom_range(15, 0);
                default: r_tgt = RST_PC + $urandom_range(255, 0);
            endcase
            cycle(r_rst, r_stl, r_rdr, r_tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
